// File: rtl/tour_pkg.sv
// Shared opcodes, headings, response codes and FSM state type for the tour command initiator.
package tour_pkg;

  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_MOVE_FF = 4'h3;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERT,
    VERT_WAIT,
    HORZ,
    HORZ_WAIT
  } tour_state_t;

endpackage

// File: rtl/tour_cmd_move_decode.sv
// One-hot knight move to vertical/horizontal command pair; lowest set bit wins.
module move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  i_move,
  output logic [15:0] o_vert_cmd,
  output logic [15:0] o_horz_cmd,
  output logic        o_valid
);

  always_comb begin
    o_vert_cmd = '0;
    o_horz_cmd = '0;
    o_valid    = |i_move;
    casez (i_move)
      8'b???????1: begin o_vert_cmd = {OP_MOVE, HDG_N, 4'd2}; o_horz_cmd = {OP_MOVE_FF, HDG_E, 4'd1}; end
      8'b??????10: begin o_vert_cmd = {OP_MOVE, HDG_N, 4'd2}; o_horz_cmd = {OP_MOVE_FF, HDG_W, 4'd1}; end
      8'b?????100: begin o_vert_cmd = {OP_MOVE, HDG_N, 4'd1}; o_horz_cmd = {OP_MOVE_FF, HDG_W, 4'd2}; end
      8'b????1000: begin o_vert_cmd = {OP_MOVE, HDG_S, 4'd1}; o_horz_cmd = {OP_MOVE_FF, HDG_W, 4'd2}; end
      8'b???10000: begin o_vert_cmd = {OP_MOVE, HDG_S, 4'd2}; o_horz_cmd = {OP_MOVE_FF, HDG_W, 4'd1}; end
      8'b??100000: begin o_vert_cmd = {OP_MOVE, HDG_S, 4'd2}; o_horz_cmd = {OP_MOVE_FF, HDG_E, 4'd1}; end
      8'b?1000000: begin o_vert_cmd = {OP_MOVE, HDG_S, 4'd1}; o_horz_cmd = {OP_MOVE_FF, HDG_E, 4'd2}; end
      8'b10000000: begin o_vert_cmd = {OP_MOVE, HDG_N, 4'd1}; o_horz_cmd = {OP_MOVE_FF, HDG_E, 4'd2}; end
      default: ;
    endcase
  end

endmodule

// File: rtl/tour_cmd.sv
// Tour command initiator: passes UART commands through in IDLE, otherwise
// issues each knight move as a vertical leg then a horizontal leg with fanfare.
module tour_cmd
  import tour_pkg::*;
#(
  parameter int unsigned NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  tour_state_t r_state, w_next;
  logic [4:0]  r_mv_indx;
  logic [7:0]  r_resp;
  logic [15:0] r_vert_cmd, r_horz_cmd;
  logic [15:0] w_vert_cmd, w_horz_cmd;
  logic        w_move_valid;
  logic        w_last;
  logic        w_leg_done;

  // The held move is kept in decoded form so both legs come straight from registers.
  move_decode u_move_decode (
    .i_move     (move),
    .o_vert_cmd (w_vert_cmd),
    .o_horz_cmd (w_horz_cmd),
    .o_valid    (w_move_valid)
  );

  assign w_last     = (r_mv_indx == LAST_IDX);
  assign w_leg_done = send_resp && (((r_state == HORZ) && clr_cmd_rdy) || (r_state == HORZ_WAIT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mv_indx  <= '0;
      r_resp     <= RESP_DONE;
      r_vert_cmd <= '0;
      r_horz_cmd <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && start_tour) begin
        r_mv_indx <= '0;
        r_resp    <= RESP_BUSY;
      end
      if (r_state == LOAD) begin
        r_vert_cmd <= w_vert_cmd;
        r_horz_cmd <= w_horz_cmd;
        if (!w_move_valid) r_resp <= RESP_DONE;
      end
      if (w_leg_done) begin
        if (w_last) r_resp    <= RESP_DONE;
        else        r_mv_indx <= r_mv_indx + 5'd1;
      end
    end
  end

  // A completion arriving with the clear skips the wait state entirely.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (start_tour) w_next = LOAD;
      LOAD:      w_next = w_move_valid ? VERT : IDLE;
      VERT:      if (clr_cmd_rdy) w_next = send_resp ? HORZ : VERT_WAIT;
      VERT_WAIT: if (send_resp) w_next = HORZ;
      HORZ:      if (clr_cmd_rdy) w_next = send_resp ? (w_last ? IDLE : LOAD) : HORZ_WAIT;
      HORZ_WAIT: if (send_resp) w_next = w_last ? IDLE : LOAD;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    cmd              = '0;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    unique case (r_state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
      end
      VERT:      begin cmd = r_vert_cmd; cmd_rdy = 1'b1; end
      VERT_WAIT: cmd = r_vert_cmd;
      HORZ:      begin cmd = r_horz_cmd; cmd_rdy = 1'b1; end
      HORZ_WAIT: cmd = r_horz_cmd;
      default: ;
    endcase
  end

  assign mv_indx = r_mv_indx;
  assign resp    = r_resp;

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd: randomized tours checked against a knight-move reference model.
module tb_tour_cmd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  logic [7:0]  mem [0:23];
  int n_cmp  = 0;
  int n_bad  = 0;
  int n_legs = 0;

  always #5 clk = ~clk;

  assign move = (mv_indx < 5'd24) ? mem[mv_indx] : 8'h00;

  tour_cmd #(.NUM_MOVES(24)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  // Knight offsets per one-hot bit; headings/counts built from the sign and magnitude.
  function automatic void model(input logic [7:0] m, output logic [15:0] v, output logic [15:0] h);
    int dy [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
    int dx [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int b = 0;
    while (b < 7 && !m[b]) b++;
    v = {4'h2, (dy[b] > 0) ? 8'h00 : 8'h7F, 4'((dy[b] > 0) ? dy[b] : -dy[b])};
    h = {4'h3, (dx[b] > 0) ? 8'hBF : 8'h3F, 4'((dx[b] > 0) ? dx[b] : -dx[b])};
  endfunction

  task automatic do_leg(input logic [15:0] exp, input int idx, input string tag, input bit rst_in_wait);
    int waited = 0;
    bit both;
    while (cmd_rdy !== 1'b1 && waited < 6) begin step; waited++; end
    chk({tag, " rdy"}, 16'(cmd_rdy), 16'd1);
    if (cmd_rdy !== 1'b1) return;
    n_legs++;
    chk({tag, " cmd"}, cmd, exp);
    chk({tag, " idx"}, 16'(mv_indx), 16'(idx));
    chk({tag, " resp busy"}, 16'(resp), 16'h5A);
    repeat ($urandom_range(0, 2)) begin
      start_tour = 1'($urandom % 2);
      step;
      start_tour = 1'b0;
      #1;
      chk({tag, " rdy hold"}, 16'(cmd_rdy), 16'd1);
      chk({tag, " cmd hold"}, cmd, exp);
    end
    if ($urandom % 3 == 0) begin
      send_resp = 1'b1;
      step;
      send_resp = 1'b0;
      #1;
      chk({tag, " lone resp ignored"}, 16'(cmd_rdy), 16'd1);
    end
    both = rst_in_wait ? 1'b0 : 1'($urandom % 2);
    clr_cmd_rdy = 1'b1;
    send_resp   = both;
    #1;
    chk({tag, " clr gated"}, 16'(clr_cmd_rdy_UART), 16'd0);
    step;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    #1;
    if (!both) begin
      chk({tag, " rdy fall"}, 16'(cmd_rdy), 16'd0);
      chk({tag, " cmd stable"}, cmd, exp);
      if (rst_in_wait) begin
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        #1;
        return;
      end
      repeat ($urandom_range(0, 3)) step;
      send_resp = 1'b1;
      step;
      send_resp = 1'b0;
      #1;
    end
  endtask

  task automatic run_tour(input int rst_at);
    logic [15:0] v, h;
    cmd_rdy_UART = 1'b0;
    cmd_UART     = {4'h8 | 4'($urandom % 8), 12'($urandom)};
    start_tour   = 1'b1;
    step;
    start_tour   = 1'b0;
    #1;
    chk("load rdy low", 16'(cmd_rdy), 16'd0);
    chk("start idx", 16'(mv_indx), 16'd0);
    chk("start resp", 16'(resp), 16'h5A);
    for (int i = 0; i < 24; i++) begin
      step;
      if (mem[i] == 8'h00) begin
        chk("abort rdy", 16'(cmd_rdy), 16'd0);
        chk("abort idle mux", cmd, cmd_UART);
        chk("abort resp", 16'(resp), 16'hA5);
        clr_cmd_rdy = 1'b1;
        #1;
        chk("abort clr passthru", 16'(clr_cmd_rdy_UART), 16'd1);
        clr_cmd_rdy = 1'b0;
        return;
      end
      chk("rdy after load", 16'(cmd_rdy), 16'd1);
      model(mem[i], v, h);
      do_leg(v, i, "vert", 1'b0);
      do_leg(h, i, "horz", i == rst_at);
      if (i == rst_at) begin
        chk("rst rdy", 16'(cmd_rdy), 16'd0);
        chk("rst idx", 16'(mv_indx), 16'd0);
        chk("rst resp", 16'(resp), 16'hA5);
        chk("rst idle mux", cmd, cmd_UART);
        return;
      end
    end
    chk("done resp", 16'(resp), 16'hA5);
    chk("done idx", 16'(mv_indx), 16'd23);
    chk("done idle mux", cmd, cmd_UART);
    chk("done rdy", 16'(cmd_rdy), 16'd0);
  endtask

  function automatic logic [7:0] rand_move();
    if ($urandom % 4 == 0) return 8'($urandom_range(1, 255));
    return 8'(1 << ($urandom % 8));
  endfunction

  initial begin
    rst_n        = 1'b0;
    start_tour   = 1'b0;
    cmd_UART     = 16'h1234;
    cmd_rdy_UART = 1'b0;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;
    for (int i = 0; i < 24; i++) mem[i] = 8'(1 << (i % 8));
    repeat (2) step;
    rst_n = 1'b1;
    #1;
    chk("reset cmd mux", cmd, 16'h1234);
    chk("reset rdy", 16'(cmd_rdy), 16'd0);
    chk("reset idx", 16'(mv_indx), 16'd0);
    chk("reset resp", 16'(resp), 16'hA5);
    chk("reset clr", 16'(clr_cmd_rdy_UART), 16'd0);

    cmd_UART     = 16'h2002;
    cmd_rdy_UART = 1'b1;
    #1;
    chk("pass cmd", cmd, 16'h2002);
    chk("pass rdy", 16'(cmd_rdy), 16'd1);
    clr_cmd_rdy = 1'b1;
    #1;
    chk("pass clr", 16'(clr_cmd_rdy_UART), 16'd1);
    clr_cmd_rdy  = 1'b0;
    cmd_rdy_UART = 1'b0;
    step;

    n_legs = 0;
    run_tour(-1);
    chk("full tour legs", 16'(n_legs), 16'd48);

    for (int i = 0; i < 24; i++) mem[i] = rand_move();
    mem[5] = 8'h00;
    step;
    run_tour(-1);

    for (int i = 0; i < 24; i++) mem[i] = rand_move();
    step;
    run_tour(2);
    step;
    n_legs = 0;
    run_tour(-1);
    chk("restart tour legs", 16'(n_legs), 16'd48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
